uart_ctrl: RTL and testbench

Memory-mapped controller between the CPU data bus and the `uart` block. Buffers outgoing bytes in a small TX FIFO and sequences each byte into `uart` with a hold-until-acknowledged `tx_enable` handshake. Captures received bytes into a holding register with valid and overflow flags, and raises an interrupt request. `uart` runs its protocol on a slow derived clock, so every `uart` status input is synchronized and edge-detected here.

---
 rtl/uart_ctrl_pkg.sv | 33 +++
 rtl/uart_ctrl_if.sv | 26 ++
 rtl/uart_ctrl_tx_fifo.sv | 55 +++++
 rtl/uart_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for uart_ctrl: register offsets, CON bit layout, TX FSM encodings.
package uart_ctrl_pkg;

  localparam logic [31:0] OFS_TXD = 32'd0;
  localparam logic [31:0] OFS_RXD = 32'd4;
  localparam logic [31:0] OFS_CON = 32'd8;

  localparam int CON_TX_INT_EN = 0;
  localparam int CON_RX_INT_EN = 1;
  localparam int CON_TX_BUSY   = 2;
  localparam int CON_RX_VALID  = 3;
  localparam int CON_TX_FULL   = 4;
  localparam int CON_TX_OVF    = 5;
  localparam int CON_RX_OVF    = 6;
  localparam int CON_TX_DONE   = 7;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  // Field order matches the CON bit indices above, MSB first.
  typedef struct packed {
    logic tx_done;
    logic rx_ovf;
    logic tx_ovf;
    logic tx_full;
    logic rx_valid;
    logic tx_busy;
    logic rx_int_en;
    logic tx_int_en;
  } con_t;

endpackage

// File: rtl/uart_ctrl_if.sv
// CPU bus and uart-side signals of uart_ctrl.
// The slave modport is the controller's view; master is the bus/uart environment.
interface uart_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        rx_enable;
  logic        tx_status;
  logic        rx_flag;
  logic [7:0]  rx_data;

  modport slave (
    input  addr, wdata, mem_read, mem_write, tx_status, rx_flag, rx_data,
    output rdata, irq, tx_data, tx_enable, rx_enable
  );

  modport master (
    output addr, wdata, mem_read, mem_write, tx_status, rx_flag, rx_data,
    input  rdata, irq, tx_data, tx_enable, rx_enable
  );
endinterface

// File: rtl/uart_ctrl_tx_fifo.sv
// uart_tx_fifo: byte FIFO, push visible after the push edge, head readable combinationally.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_wdat,
  input  logic          i_pop,
  output logic [7:0]    o_rdat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] L_FULL = DEPTH[AW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == L_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdat  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdat;
  end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped TX FIFO + RX holding register in front of a slow-clock uart.
// tx_enable rises 1 cycle after a TXD write into an idle path; RX capture 3 cycles after rx_flag.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h4000_0018,
  parameter int          TX_DEPTH = 4
) (
  input  logic         sysclk,
  input  logic         reset_n,
  uart_ctrl_if.slave   bus
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic          w_sel_txd, w_sel_rxd, w_sel_con;
  logic          w_wr_txd, w_wr_con, w_rd_rxd;
  logic          r_txs_meta, r_txs_sync;
  logic          r_rxf_meta, r_rxf_sync, r_rxf_prev;
  logic          w_tx_st, w_rx_rise;
  logic [1:0]    r_state;
  logic [7:0]    r_tx_data;
  logic          w_pop, w_full, w_empty;
  logic [7:0]    w_fifo_rdat;
  logic [CW-1:0] w_count;
  logic          r_tx_int_en, r_rx_int_en;
  logic          r_tx_ovf, r_rx_ovf, r_tx_done, r_rx_valid;
  logic [7:0]    r_rx_buf;
  logic          r_irq, r_rx_en;
  logic          w_tx_busy, w_tx_done_set, w_tx_ovf_set, w_rx_ovf_set;
  con_t          w_con;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_sel_txd = (bus.addr == BASE + OFS_TXD);
  assign w_sel_rxd = (bus.addr == BASE + OFS_RXD);
  assign w_sel_con = (bus.addr == BASE + OFS_CON);
  assign w_wr_txd  = bus.mem_write & w_sel_txd;
  assign w_wr_con  = bus.mem_write & w_sel_con;
  assign w_rd_rxd  = bus.mem_read  & w_sel_rxd;
  assign w_unused  = ^bus.wdata[31:8];

  // tx_status sync resets to "busy" so a uart still finishing a frame across
  // our reset cannot be launched into before its real status is visible.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_txs_meta <= 1'b1;
      r_txs_sync <= 1'b1;
      r_rxf_meta <= 1'b0;
      r_rxf_sync <= 1'b0;
      r_rxf_prev <= 1'b0;
    end else begin
      r_txs_meta <= bus.tx_status;
      r_txs_sync <= r_txs_meta;
      r_rxf_meta <= bus.rx_flag;
      r_rxf_sync <= r_rxf_meta;
      r_rxf_prev <= r_rxf_sync;
    end
  end

  assign w_tx_st   = r_txs_sync;
  assign w_rx_rise = r_rxf_sync & ~r_rxf_prev;

  assign w_pop = (r_state == ST_IDLE) & ~w_empty & ~w_tx_st;

  uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .i_clk   (sysclk),
    .i_rst_n (reset_n),
    .i_push  (w_wr_txd),
    .i_wdat  (bus.wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdat  (w_fifo_rdat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_tx_data <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state   <= ST_LAUNCH;
            r_tx_data <= w_fifo_rdat;
          end
        end
        ST_LAUNCH:    if (w_tx_st)  r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!w_tx_st) r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_tx_done_set = (r_state == ST_WAIT_DONE) & ~w_tx_st;
  assign w_tx_ovf_set  = w_wr_txd & w_full & ~w_pop;
  assign w_rx_ovf_set  = w_rx_rise & r_rx_valid & ~w_rd_rxd;
  assign w_tx_busy     = (w_count != '0) | (r_state != ST_IDLE);

  // Sticky flags: a set in the same cycle as a write-1-to-clear takes priority.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_int_en <= 1'b0;
      r_rx_int_en <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_tx_done   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_buf    <= 8'h00;
      r_irq       <= 1'b0;
      r_rx_en     <= 1'b0;
    end else begin
      r_rx_en <= 1'b1;
      if (w_wr_con) begin
        r_tx_int_en <= bus.wdata[CON_TX_INT_EN];
        r_rx_int_en <= bus.wdata[CON_RX_INT_EN];
      end
      r_tx_ovf  <= w_tx_ovf_set  | (r_tx_ovf  & ~(w_wr_con & bus.wdata[CON_TX_OVF]));
      r_rx_ovf  <= w_rx_ovf_set  | (r_rx_ovf  & ~(w_wr_con & bus.wdata[CON_RX_OVF]));
      r_tx_done <= w_tx_done_set | (r_tx_done & ~(w_wr_con & bus.wdata[CON_TX_DONE]));
      if (w_rx_rise) begin
        r_rx_buf   <= bus.rx_data;
        r_rx_valid <= 1'b1;
      end else if (w_rd_rxd) begin
        r_rx_valid <= 1'b0;
      end
      r_irq <= (r_tx_int_en & r_tx_done) | (r_rx_int_en & r_rx_valid);
    end
  end

  assign w_con = {r_tx_done, r_rx_ovf, r_tx_ovf, w_full,
                  r_rx_valid, w_tx_busy, r_rx_int_en, r_tx_int_en};

  always_comb begin
    w_rdata = 32'h0;
    if (bus.mem_read) begin
      if (w_sel_rxd)      w_rdata = {24'h0, r_rx_buf};
      else if (w_sel_con) w_rdata = {24'h0, w_con};
    end
  end

  assign bus.rdata     = w_rdata;
  assign bus.irq       = r_irq;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_enable = (r_state == ST_LAUNCH);
  assign bus.rx_enable = r_rx_en;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: bus accesses plus a hand-driven uart handshake.
module tb_uart_ctrl;

  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 sysclk = ~sysclk;

  uart_ctrl_if u_if ();

  uart_ctrl #(.BASE(TXD), .TX_DEPTH(4)) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    u_if.addr = a; u_if.wdata = d; u_if.mem_write = 1'b1;
    tick(1);
    u_if.mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    u_if.addr = a; u_if.mem_read = 1'b1;
    #1 d = u_if.rdata;
    tick(1);
    u_if.mem_read = 1'b0;
  endtask

  task automatic wait_txen(input logic val, input int max);
    int n = 0;
    while (u_if.tx_enable !== val && n < max) begin
      tick(1);
      n++;
    end
  endtask

  task automatic uart_xfer(input logic [7:0] b);
    wait_txen(1'b1, 20);
    check("xfer_en", {31'h0, u_if.tx_enable}, 32'h1);
    check("xfer_data", {24'h0, u_if.tx_data}, {24'h0, b});
    u_if.tx_status = 1'b1;
    wait_txen(1'b0, 3);
    check("xfer_en_fall", {31'h0, u_if.tx_enable}, 32'h0);
    tick(4);
    u_if.tx_status = 1'b0;
    tick(4);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    u_if.rx_data = b; u_if.rx_flag = 1'b1;
    tick(40);
    u_if.rx_flag = 1'b0;
    tick(10);
  endtask

  initial begin
    logic [31:0] d;
    u_if.addr = '0; u_if.wdata = '0; u_if.mem_read = 1'b0; u_if.mem_write = 1'b0;
    u_if.tx_status = 1'b0; u_if.rx_flag = 1'b0; u_if.rx_data = '0;

    tick(2);
    check("rst_tx_enable", {31'h0, u_if.tx_enable}, 32'h0);
    check("rst_tx_data", {24'h0, u_if.tx_data}, 32'h0);
    check("rst_irq", {31'h0, u_if.irq}, 32'h0);
    check("rst_rx_enable", {31'h0, u_if.rx_enable}, 32'h0);
    reset_n = 1'b1;
    #1 check("rx_enable_before_edge", {31'h0, u_if.rx_enable}, 32'h0);
    tick(1);
    check("rx_enable_after_edge", {31'h0, u_if.rx_enable}, 32'h1);
    tick(3);
    rd(CON, d); check("rst_con", d, 32'h0);
    rd(RXD, d); check("rst_rxd", d, 32'h0);
    rd(TXD, d); check("txd_reads_zero", d, 32'h0);

    // single byte
    wr(TXD, 32'h55);
    check("t1_en_at_write", {31'h0, u_if.tx_enable}, 32'h0);
    tick(1);
    check("t1_en_next", {31'h0, u_if.tx_enable}, 32'h1);
    check("t1_data", {24'h0, u_if.tx_data}, 32'h55);
    u_if.tx_status = 1'b1;
    wait_txen(1'b0, 3);
    check("t1_en_fall", {31'h0, u_if.tx_enable}, 32'h0);
    check("t1_data_hold", {24'h0, u_if.tx_data}, 32'h55);
    rd(CON, d); check("t1_busy", d, 32'h04);
    u_if.tx_status = 1'b0;
    tick(4);
    rd(CON, d); check("t1_done", d, 32'h80);
    check("t1_irq_masked", {31'h0, u_if.irq}, 32'h0);
    wr(CON, 32'h01);
    tick(1);
    check("t1_irq_on", {31'h0, u_if.irq}, 32'h1);
    wr(CON, 32'h80);
    tick(1);
    check("t1_irq_off", {31'h0, u_if.irq}, 32'h0);
    rd(CON, d); check("t1_con_clr", d, 32'h0);

    // six back-to-back writes into a depth-4 FIFO
    for (int i = 1; i <= 6; i++) begin
      u_if.addr = TXD; u_if.wdata = i; u_if.mem_write = 1'b1;
      tick(1);
    end
    u_if.mem_write = 1'b0;
    check("t2_en", {31'h0, u_if.tx_enable}, 32'h1);
    check("t2_first", {24'h0, u_if.tx_data}, 32'h01);
    rd(CON, d); check("t2_full_ovf", d, 32'h34);
    for (int i = 1; i <= 5; i++) uart_xfer(8'(i));
    rd(CON, d); check("t2_after", d, 32'hA0);
    wr(CON, 32'hA0);
    rd(CON, d); check("t2_w1c", d, 32'h0);

    // rx capture with interrupt
    wr(CON, 32'h02);
    u_if.rx_data = 8'hA7; u_if.rx_flag = 1'b1;
    tick(2);
    rd(CON, d); check("t3_not_yet", d, 32'h02);
    rd(CON, d); check("t3_valid", d, 32'h0A);
    check("t3_irq", {31'h0, u_if.irq}, 32'h1);
    tick(640);
    u_if.rx_flag = 1'b0;
    rd(RXD, d); check("t3_rxd", d, 32'hA7);
    tick(1);
    check("t3_irq_clr", {31'h0, u_if.irq}, 32'h0);
    rd(CON, d); check("t3_valid_clr", d, 32'h02);

    // rx overflow
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    rd(CON, d); check("t4_ovf", d, 32'h4A);
    rd(RXD, d); check("t4_rxd", d, 32'h22);
    rd(CON, d); check("t4_after_rd", d, 32'h42);
    wr(CON, 32'h40);
    rd(CON, d); check("t4_ovf_clr", d, 32'h0);

    // capture coinciding with an RXD read
    rx_pulse(8'h33);
    rd(CON, d); check("t5_pre", d, 32'h08);
    u_if.rx_data = 8'h44; u_if.rx_flag = 1'b1;
    tick(2);
    rd(RXD, d); check("t5_old", d, 32'h33);
    rd(CON, d); check("t5_capture_wins", d, 32'h08);
    rd(RXD, d); check("t5_new", d, 32'h44);
    u_if.rx_flag = 1'b0;
    tick(5);
    rd(CON, d); check("t5_end", d, 32'h0);

    // reset in WAIT_DONE with the uart still busy
    wr(TXD, 32'h77);
    wait_txen(1'b1, 5);
    check("t6_en", {31'h0, u_if.tx_enable}, 32'h1);
    u_if.tx_status = 1'b1;
    wait_txen(1'b0, 3);
    check("t6_wait_done", {31'h0, u_if.tx_enable}, 32'h0);
    wr(TXD, 32'h78);
    wr(TXD, 32'h79);
    wr(CON, 32'h03);
    rd(CON, d); check("t6_pre_rst", d, 32'h07);
    reset_n = 1'b0;
    #1;
    check("t6_rst_en", {31'h0, u_if.tx_enable}, 32'h0);
    check("t6_rst_data", {24'h0, u_if.tx_data}, 32'h0);
    check("t6_rst_irq", {31'h0, u_if.irq}, 32'h0);
    check("t6_rst_rx_enable", {31'h0, u_if.rx_enable}, 32'h0);
    u_if.addr = CON; u_if.mem_read = 1'b1;
    #1 check("t6_rst_con", u_if.rdata, 32'h0);
    u_if.mem_read = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    wr(TXD, 32'h99);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t6_hold_off", {31'h0, u_if.tx_enable}, 32'h0);
    end
    rd(CON, d); check("t6_queued", d, 32'h04);
    u_if.tx_status = 1'b0;
    wait_txen(1'b1, 6);
    check("t6_launch", {31'h0, u_if.tx_enable}, 32'h1);
    check("t6_data", {24'h0, u_if.tx_data}, 32'h99);
    u_if.tx_status = 1'b1;
    wait_txen(1'b0, 3);
    check("t6_en_fall", {31'h0, u_if.tx_enable}, 32'h0);
    u_if.tx_status = 1'b0;
    tick(5);
    rd(CON, d); check("t6_done", d, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
